// File: rtl/AluCtrlSig_pkg.sv
// Shared MIPS opcode/funct constants plus the instruction-kind and encoder-state
// enums used by the instruction encoder.
package AluCtrlSig_pkg;

  localparam logic [5:0] LW_op     = 6'b100011;
  localparam logic [5:0] SW_op     = 6'b101011;
  localparam logic [5:0] ADDI_op   = 6'b001000;
  localparam logic [5:0] BEQ_op    = 6'b000100;
  localparam logic [5:0] BNE_op    = 6'b000101;
  localparam logic [5:0] ADD_op    = 6'b000000;
  localparam logic [5:0] JMP_op    = 6'b000010;
  localparam logic [5:0] ADD_funct = 6'b100000;

  // Encoding 3'd7 is deliberately left unused; it marks an invalid request.
  typedef enum logic [2:0] {
    KIND_LW   = 3'd0,
    KIND_SW   = 3'd1,
    KIND_ADDI = 3'd2,
    KIND_BEQ  = 3'd3,
    KIND_BNE  = 3'd4,
    KIND_ADD  = 3'd5,
    KIND_JMP  = 3'd6
  } instr_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } enc_state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake and instruction-memory write port of the encoder.
// master = boot host / memory side, slave = encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              imem_we;
  logic              imem_busy;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
    output imem_busy,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
    input  imem_busy,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational field-to-word packer; flags kinds outside the
// instruction set as invalid.
module instr_pack
  import AluCtrlSig_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        invalid
);

  always_comb begin
    word    = '0;
    invalid = 1'b0;
    case (kind)
      KIND_LW:   word = {LW_op,   rs, rt, imm};
      KIND_SW:   word = {SW_op,   rs, rt, imm};
      KIND_ADDI: word = {ADDI_op, rs, rt, imm};
      KIND_BEQ:  word = {BEQ_op,  rs, rt, imm};
      KIND_BNE:  word = {BNE_op,  rs, rt, imm};
      KIND_ADD:  word = {ADD_op,  rs, rt, rd, 5'b00000, ADD_funct};
      KIND_JMP:  word = {JMP_op,  target};
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field-level requests, packs them into MIPS words and
// writes them to consecutive imem addresses. Macro: INSTR_ENC_BRANCH_REL_EN.
module instr_encoder
  import AluCtrlSig_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  instr_encoder_if.slave  bus,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] count
);

  enc_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       wdata_q;
  logic              last_q;
  logic              ready_q;
  logic              we_q;
  logic              done_q;
  logic              err_q;
  logic [15:0]       imm_field;
  logic [31:0]       enc_word;
  logic              kind_invalid;

  // Branch offsets are taken relative to the word after the one being written.
  always_comb begin
    imm_field = bus.in_imm;
`ifdef INSTR_ENC_BRANCH_REL_EN
    if (bus.in_kind == KIND_BEQ || bus.in_kind == KIND_BNE)
      imm_field = bus.in_imm - 16'(addr_q) - 16'd1;
`endif
  end

  instr_pack u_pack (
    .kind    (bus.in_kind),
    .rs      (bus.in_rs),
    .rt      (bus.in_rt),
    .rd      (bus.in_rd),
    .imm     (imm_field),
    .target  (bus.in_target),
    .word    (enc_word),
    .invalid (kind_invalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (start) begin
      // A pending uncommitted word is simply dropped.
      state   <= ST_ACCEPT;
      addr_q  <= ADDR_W'(BASE_ADDR);
      count_q <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (bus.in_valid) begin
            ready_q <= 1'b0;
            if (kind_invalid) begin
              state <= ST_ERR;
              err_q <= 1'b1;
            end else begin
              state   <= ST_WRITE;
              wdata_q <= enc_word;
              last_q  <= bus.in_last;
              we_q    <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (!bus.imem_busy) begin
            we_q    <= 1'b0;
            addr_q  <= addr_q + ADDR_W'(1);
            count_q <= count_q + (ADDR_W+1)'(1);
            if (last_q) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else if (addr_q == '1) begin
              // Overflow is caught before the address wraps onto word 0.
              state <= ST_ERR;
              err_q <= 1'b1;
            end else begin
              state   <= ST_ACCEPT;
              ready_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign done           = done_q;
  assign err            = err_q;
  assign count          = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a wide instance for function/stall/branch tests and
// an ADDR_W=2 instance for address overflow, checked against an arithmetic model.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b;
  logic        req_valid;
  logic [2:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        req_last;
  logic        busy;

  logic       done_a, err_a, done_b, err_b;
  logic [8:0] count_a;
  logic [2:0] count_b;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder_if #(.ADDR_W(8)) bus_a ();
  instr_encoder_if #(.ADDR_W(2)) bus_b ();

  assign bus_a.in_valid  = req_valid;
  assign bus_a.in_kind   = req_kind;
  assign bus_a.in_rs     = req_rs;
  assign bus_a.in_rt     = req_rt;
  assign bus_a.in_rd     = req_rd;
  assign bus_a.in_imm    = req_imm;
  assign bus_a.in_target = req_target;
  assign bus_a.in_last   = req_last;
  assign bus_a.imem_busy = busy;
  assign bus_b.in_valid  = req_valid;
  assign bus_b.in_kind   = req_kind;
  assign bus_b.in_rs     = req_rs;
  assign bus_b.in_rt     = req_rt;
  assign bus_b.in_rd     = req_rd;
  assign bus_b.in_imm    = req_imm;
  assign bus_b.in_target = req_target;
  assign bus_b.in_last   = req_last;
  assign bus_b.imem_busy = busy;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start_a), .bus(bus_a),
    .done(done_a), .err(err_a), .count(count_a)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
    .done(done_b), .err(err_b), .count(count_b)
  );

  // Commit log: a write lands on an edge with we=1 and busy=0.
  logic [7:0]  ca_addr[$];
  logic [31:0] ca_data[$];
  logic [1:0]  cb_addr[$];

  always @(posedge clk) begin
    if (bus_a.imem_we === 1'b1 && bus_a.imem_busy === 1'b0) begin
      ca_addr.push_back(bus_a.imem_addr);
      ca_data.push_back(bus_a.imem_wdata);
    end
    if (bus_b.imem_we === 1'b1 && bus_b.imem_busy === 1'b0)
      cb_addr.push_back(bus_b.imem_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoder built from the MIPS field layout with plain arithmetic.
  function automatic logic [31:0] ref_encode(input int kind, input int rs, input int rt,
                                             input int rd, input int imm, input int target,
                                             input int addr);
    longint w;
    longint f;
    f = imm;
`ifdef INSTR_ENC_BRANCH_REL_EN
    if (kind == 3 || kind == 4) f = ((imm - addr - 1) % 65536 + 65536) % 65536;
`else
    if (addr < 0) f = imm;
`endif
    case (kind)
      0: w = 35 * 64'd67108864 + rs * 2097152 + rt * 65536 + f;
      1: w = 43 * 64'd67108864 + rs * 2097152 + rt * 65536 + f;
      2: w = 8  * 64'd67108864 + rs * 2097152 + rt * 65536 + f;
      3: w = 4  * 64'd67108864 + rs * 2097152 + rt * 65536 + f;
      4: w = 5  * 64'd67108864 + rs * 2097152 + rt * 65536 + f;
      5: w = rs * 2097152 + rt * 65536 + rd * 2048 + 32;
      default: w = 2 * 64'd67108864 + target;
    endcase
    return w[31:0];
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.in_ready : bus_a.in_ready;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input bit sel, input int kind, input int rs, input int rt, input int rd,
                      input int imm, input int target, input bit last, input int nmax,
                      output bit acc);
    int n;
    n = 0;
    req_kind   = 3'(kind);
    req_rs     = 5'(rs);
    req_rt     = 5'(rt);
    req_rd     = 5'(rd);
    req_imm    = 16'(imm);
    req_target = 26'(target);
    req_last   = last;
    req_valid  = 1'b1;
    while (rdy(sel) !== 1'b1 && n < nmax) begin
      tick();
      n++;
    end
    acc = (rdy(sel) === 1'b1);
    if (acc) tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus_a.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus_a.in_ready); end
    n_cmp++; if (bus_a.imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus_a.imem_we); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_a); end
    n_cmp++; if (bus_a.imem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", bus_a.imem_addr); end
    n_cmp++; if (bus_a.imem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", bus_a.imem_wdata); end
    n_cmp++; if (count_a !== 9'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count_a); end
    n_cmp++; if (bus_b.in_ready !== 1'b0 || err_b !== 1'b0) begin n_bad++; $display("FAIL reset_small: got ready=%b err=%b want 0 0", bus_b.in_ready, err_b); end
    rst = 1'b0;
    tick();
    // A request with no session open must be ignored.
    req_valid = 1'b1;
    repeat (3) tick();
    req_valid = 1'b0;
    n_cmp++; if (ca_addr.size() != 0 || bus_a.in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ignore: got writes=%0d ready=%b want 0 0", ca_addr.size(), bus_a.in_ready); end
  endtask

  task automatic test_add();
    bit acc;
    ca_addr.delete(); ca_data.delete();
    pulse_start(0);
    send(0, 5, 1, 2, 3, 0, 0, 1'b1, 10, acc);
    n_cmp++; if (bus_a.imem_we !== 1'b1) begin n_bad++; $display("FAIL add_we: got %b want 1", bus_a.imem_we); end
    n_cmp++; if (bus_a.imem_addr !== 8'd0) begin n_bad++; $display("FAIL add_addr: got %h want 00", bus_a.imem_addr); end
    n_cmp++; if (bus_a.imem_wdata !== 32'h00221820) begin n_bad++; $display("FAIL add_wdata: got %h want 00221820", bus_a.imem_wdata); end
    tick();
    n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL add_done: got %b want 1", done_a); end
    n_cmp++; if (count_a !== 9'd1) begin n_bad++; $display("FAIL add_count: got %0d want 1", count_a); end
    tick();
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL add_done_pulse: got %b want 0", done_a); end
  endtask

  task automatic test_lw_jmp();
    bit acc;
    int n;
    ca_addr.delete(); ca_data.delete();
    pulse_start(0);
    send(0, 0, 0, 8, 0, 4, 0, 1'b0, 10, acc);
    send(0, 6, 0, 0, 0, 0, 'h10, 1'b1, 10, acc);
    n = 0;
    while (done_a !== 1'b1 && n < 20) begin tick(); n++; end
    n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL lwjmp_done: got %b want 1", done_a); end
    n_cmp++; if (ca_addr.size() != 2) begin n_bad++; $display("FAIL lwjmp_writes: got %0d want 2", ca_addr.size()); end
    else begin
      n_cmp++; if (ca_addr[0] !== 8'd0 || ca_data[0] !== 32'h8C080004) begin n_bad++; $display("FAIL lwjmp_w0: got %h@%h want 8c080004@00", ca_data[0], ca_addr[0]); end
      n_cmp++; if (ca_addr[1] !== 8'd1 || ca_data[1] !== 32'h08000010) begin n_bad++; $display("FAIL lwjmp_w1: got %h@%h want 08000010@01", ca_data[1], ca_addr[1]); end
    end
    n_cmp++; if (count_a !== 9'd2) begin n_bad++; $display("FAIL lwjmp_count: got %0d want 2", count_a); end
    tick();
  endtask

  task automatic test_stall();
    bit acc;
    int rs, rt, imm;
    logic [31:0] ew;
    ca_addr.delete(); ca_data.delete();
    rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
    ew = ref_encode(2, rs, rt, 0, imm, 0, 0);
    pulse_start(0);
    busy = 1'b1;
    send(0, 2, rs, rt, 0, imm, 0, 1'b1, 10, acc);
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (bus_a.imem_we !== 1'b1) begin n_bad++; $display("FAIL stall_we[%0d]: got %b want 1", c, bus_a.imem_we); end
      n_cmp++; if (bus_a.imem_addr !== 8'd0) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h want 00", c, bus_a.imem_addr); end
      n_cmp++; if (bus_a.imem_wdata !== ew) begin n_bad++; $display("FAIL stall_wdata[%0d]: got %h want %h", c, bus_a.imem_wdata, ew); end
      n_cmp++; if (bus_a.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0", c, bus_a.in_ready); end
      tick();
    end
    n_cmp++; if (ca_addr.size() != 0) begin n_bad++; $display("FAIL stall_early: got %0d writes want 0", ca_addr.size()); end
    busy = 1'b0;
    tick();
    n_cmp++; if (ca_data.size() != 1 || done_a !== 1'b1) begin n_bad++; $display("FAIL stall_commit: got writes=%0d done=%b want 1 1", ca_data.size(), done_a); end
    else begin
      n_cmp++; if (ca_data[0] !== ew) begin n_bad++; $display("FAIL stall_data: got %h want %h", ca_data[0], ew); end
    end
    tick();
  endtask

  task automatic test_branch();
    bit acc;
    logic [31:0] exp_q[$];
    int k, rs, rt, rd, imm, tg;
    int kinds[5] = '{0, 1, 2, 5, 6};
    ca_addr.delete(); ca_data.delete();
    pulse_start(0);
    for (int i = 0; i < 5; i++) begin
      k = kinds[$urandom_range(0, 4)];
      rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
      imm = $urandom_range(0, 65535); tg = $urandom_range(0, 67108863);
      exp_q.push_back(ref_encode(k, rs, rt, rd, imm, tg, i));
      send(0, k, rs, rt, rd, imm, tg, 1'b0, 10, acc);
      tick();
    end
    exp_q.push_back(ref_encode(3, 1, 2, 0, 2, 0, 5));
    send(0, 3, 1, 2, 0, 2, 0, 1'b1, 10, acc);
    tick();
    n_cmp++; if (ca_data.size() != 6 || done_a !== 1'b1) begin n_bad++; $display("FAIL br_writes: got %0d done=%b want 6 1", ca_data.size(), done_a); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (ca_addr[i] !== 8'(i) || ca_data[i] !== exp_q[i]) begin n_bad++; $display("FAIL br_word[%0d]: got %h@%h want %h@%h", i, ca_data[i], ca_addr[i], exp_q[i], i); end
      end
`ifdef INSTR_ENC_BRANCH_REL_EN
      n_cmp++; if (ca_data[5] !== 32'h1022FFFC) begin n_bad++; $display("FAIL br_beq: got %h want 1022fffc", ca_data[5]); end
`else
      n_cmp++; if (ca_data[5] !== 32'h10220002) begin n_bad++; $display("FAIL br_beq: got %h want 10220002", ca_data[5]); end
`endif
    end
    tick();
  endtask

  task automatic test_invalid();
    bit acc;
    ca_addr.delete(); ca_data.delete();
    pulse_start(0);
    send(0, 7, 1, 2, 3, 4, 5, 1'b0, 10, acc);
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL inv_err: got %b want 1", err_a); end
    n_cmp++; if (bus_a.in_ready !== 1'b0 || bus_a.imem_we !== 1'b0) begin n_bad++; $display("FAIL inv_ready_we: got %b %b want 0 0", bus_a.in_ready, bus_a.imem_we); end
    send(0, 5, 1, 2, 3, 0, 0, 1'b1, 6, acc);
    n_cmp++; if (acc !== 1'b0 || ca_addr.size() != 0) begin n_bad++; $display("FAIL inv_blocked: got acc=%b writes=%0d want 0 0", acc, ca_addr.size()); end
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL inv_sticky: got %b want 1", err_a); end
    pulse_start(0);
    n_cmp++; if (err_a !== 1'b0 || bus_a.in_ready !== 1'b1) begin n_bad++; $display("FAIL inv_restart: got err=%b ready=%b want 0 1", err_a, bus_a.in_ready); end
    send(0, 5, 4, 5, 6, 0, 0, 1'b1, 10, acc);
    tick();
    n_cmp++; if (ca_data.size() != 1 || done_a !== 1'b1) begin n_bad++; $display("FAIL inv_recover: got writes=%0d done=%b want 1 1", ca_data.size(), done_a); end
    else begin
      n_cmp++; if (ca_data[0] !== ref_encode(5, 4, 5, 6, 0, 0, 0)) begin n_bad++; $display("FAIL inv_word: got %h want %h", ca_data[0], ref_encode(5, 4, 5, 6, 0, 0, 0)); end
    end
    tick();
  endtask

  task automatic test_random();
    bit acc;
    int nreq, k, rs, rt, rd, imm, tg, nb, n;
    logic [31:0] ew;
    for (int s = 0; s < 4; s++) begin
      nreq = $urandom_range(1, 8);
      ca_addr.delete(); ca_data.delete();
      pulse_start(0);
      for (int i = 0; i < nreq; i++) begin
        k = $urandom_range(0, 6);
        rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
        imm = $urandom_range(0, 65535); tg = $urandom_range(0, 67108863);
        ew = ref_encode(k, rs, rt, rd, imm, tg, i);
        send(0, k, rs, rt, rd, imm, tg, i == nreq - 1, 10, acc);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL rnd_accept[%0d.%0d]: got %b want 1", s, i, acc); end
        nb = ca_addr.size();
        n = 0;
        while (ca_addr.size() == nb && n < 20) begin
          busy = ($urandom_range(0, 2) == 0);
          tick();
          n++;
        end
        busy = 1'b0;
        n_cmp++; if (ca_addr.size() != nb + 1) begin n_bad++; $display("FAIL rnd_commit[%0d.%0d]: got %0d writes want %0d", s, i, ca_addr.size(), nb + 1); end
        else if (ca_addr[nb] !== 8'(i) || ca_data[nb] !== ew) begin
          n_bad++; $display("FAIL rnd_word[%0d.%0d]: got %h@%h want %h@%h", s, i, ca_data[nb], ca_addr[nb], ew, i);
        end
      end
      n_cmp++; if (done_a !== 1'b1 || count_a !== 9'(nreq)) begin n_bad++; $display("FAIL rnd_done[%0d]: got done=%b count=%0d want 1 %0d", s, done_a, count_a, nreq); end
      tick();
    end
  endtask

  task automatic test_overflow();
    bit acc;
    cb_addr.delete();
    pulse_start(1);
    for (int i = 0; i < 5; i++) begin
      send(1, $urandom_range(0, 6), $urandom_range(0, 31), $urandom_range(0, 31), 0,
           $urandom_range(0, 65535), 0, 1'b0, 8, acc);
      if (i < 4) begin
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL ovf_accept[%0d]: got %b want 1", i, acc); end
        tick();
      end else begin
        n_cmp++; if (acc !== 1'b0) begin n_bad++; $display("FAIL ovf_fifth: got accepted=%b want 0", acc); end
      end
    end
    n_cmp++; if (err_b !== 1'b1 || count_b !== 3'd4) begin n_bad++; $display("FAIL ovf_err: got err=%b count=%0d want 1 4", err_b, count_b); end
    n_cmp++; if (cb_addr.size() != 4) begin n_bad++; $display("FAIL ovf_writes: got %0d want 4", cb_addr.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (cb_addr[i] !== 2'(i)) begin n_bad++; $display("FAIL ovf_addr[%0d]: got %0d want %0d", i, cb_addr[i], i); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; busy = 1'b0;
    req_valid = 1'b0; req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0;
    req_imm = '0; req_target = '0; req_last = 1'b0;
    test_reset();
    test_add();
    test_lw_jmp();
    test_stall();
    test_branch();
    test_invalid();
    test_random();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader. It accepts field-level instruction requests over a valid/ready handshake, packs each into a 32-bit MIPS word, and writes the words to consecutive instruction-memory addresses. It is the inverse of the opcode decoder in the control path: it produces the words that the decoder consumes. It sits between the testbench/boot host and the instruction memory write port.

## Interface
- ADDR_W, 8, word-address width of instruction memory
- BASE_ADDR, 0, first word address written after start
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load session (also aborts any session in progress)
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_kind  in  3  instr_kind_t: LW, SW, ADDI, BEQ, BNE, ADD, JMP (encodings 0–6; 7 is invalid)
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch field
- in_target  in  26  jump target field
- in_last  in  1  final instruction of the session
- imem_we  out  1  write strobe
- imem_busy  in  1  memory stall; a write commits only on a cycle with imem_we=1 and imem_busy=0
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- done  out  1  one-cycle pulse when the session completes
- err  out  1  sticky error flag
- count  out  ADDR_W+1  number of words committed in the current session

## Operation
- Formats:
  - LW, SW, ADDI, BEQ, BNE: {op, rs, rt, imm}.
  - ADD: {6'b000000, rs, rt, rd, 5'b0, 6'b100000}.
  - JMP: {6'b000010, target}.
  - Opcodes are the shared *_op constants.
- States:
  - IDLE: in_ready=0. start moves to ACCEPT with addr=BASE_ADDR and count=0.
  - ACCEPT: in_ready=1. On in_valid, either register the encoded word and in_last, then go to WRITE; or, if in_kind=7, go to ERR.
  - WRITE: imem_we=1, with imem_addr and imem_wdata held stable. On the commit cycle, count and addr are incremented. The next state is DONE if last was set. It is ERR if the committed addr was 2^ADDR_W−1 (overflow). Otherwise it is ACCEPT.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: err=1 and in_ready=0. The state is left only by start, which clears err and begins a new session.
- start has priority over everything in any state. It abandons an uncommitted word with no write, and the memory is not rolled back.
- in_valid without a session (IDLE, DONE, ERR) is ignored.
- rst: state=IDLE. in_ready, imem_we, done, err are 0; imem_addr=0, imem_wdata=0, count=0.

## Timing
- in_ready is decoded from state only and does not depend on in_valid.
- Accept at cycle N leads to imem_we=1 at N+1. With no stall the commit is at N+1 and in_ready returns at N+2. Throughput is one word per 2 cycles.
- Each stall cycle adds one cycle. imem_we stays high throughout.
- done rises the cycle after the last commit.
- Address arithmetic is modulo 2^ADDR_W. Overflow is detected before the wrap, so no silent overwrite occurs.

## Configuration
- INSTR_ENC_BRANCH_REL_EN defined: for BEQ/BNE, in_imm is an absolute word address. The encoded field is (in_imm − (addr+1)) truncated to 16 bits, computed at accept from the current addr. Other kinds are unchanged.
- Not defined: in_imm is placed verbatim for every kind.

## Structure
- AluCtrlSig_pkg holds the opcode constants (LW_op … JMP_op) and the ADD funct constant.
- The same package gains instr_kind_t and the encoder state enum.
- One combinational sub-module, instr_pack, maps kind and fields to a 32-bit word plus an invalid flag. The FSM, address counter and output registers stay in instr_encoder.

## Test plan
- start; ADD rs=1 rt=2 rd=3 last=1 -> imem_we at addr 0 with wdata=0x00221820, done pulse next cycle, count=1.
- start; LW rs=0 rt=8 imm=4, then JMP target=0x10 last=1 -> addr0=0x8C080004, addr1=0x08000010, count=2.
- imem_busy high for 3 cycles during WRITE -> imem_we, addr and wdata held; in_ready=0; commit on the 4th cycle.
- With INSTR_ENC_BRANCH_REL_EN: write 5 words, then BEQ rs=1 rt=2 imm=2 at addr 5 -> wdata=0x1022FFFC. Without the macro, the same request gives 0x10220002.
- in_kind=7 -> err=1 and in_ready=0 with no write. start then clears err and accepts again.
- ADDR_W=2; 5 requests, none last -> 4 commits at addr 0–3, then err=1, and the 5th request is never accepted.
